// File: rtl/serial_addsub_unit_pkg.sv
// Shared definitions for the bit-serial add/subtract engine: FSM state
// encoding and default geometry.
package serial_addsub_unit_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/serial_addsub_unit_full_adder_bit.sv
// Single-bit full adder cell; the only arithmetic hardware in the serial
// engine, reused once per clock for each result bit.
module full_adder_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  // NOTE: continuous assigns cover every output on every path, so no latch can be inferred.
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_addsub_unit.sv
// Bit-serial add/subtract engine. One result bit per clock, LSB first.
// Subtraction is a + ~b + 1: B is inverted at load time and the carry
// register is seeded with 1. The *_last_bit outputs feed a downstream
// signed-overflow detector directly.
module serial_addsub_unit
  import serial_addsub_unit_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             a_last_bit,
  output logic             b_last_bit,
  output logic             sum_last_bit
);

  state_e           r_state;
  logic [WIDTH-1:0] r_opa;
  logic [WIDTH-1:0] r_opb;
  logic             r_cy;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_result;
  logic             r_carry_out;
  logic             r_busy;
  logic             r_done;
  logic             r_a_last;
  logic             r_b_last;

  logic             w_sum;
  logic             w_cout;

  // LSBs of the shifting operands plus the running carry produce one bit per clock.
  full_adder_bit u_fa (
    .a    (r_opa[0]),
    .b    (r_opb[0]),
    .cin  (r_cy),
    .s    (w_sum),
    .cout (w_cout)
  );

  // Control FSM and datapath registers; all outputs are registered here.
  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_opa       <= '0;
      r_opb       <= '0;
      r_cy        <= 1'b0;
      r_cnt       <= '0;
      r_result    <= '0;
      r_carry_out <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_a_last    <= 1'b0;
      r_b_last    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_opa    <= a;
            r_opb    <= b ^ {WIDTH{sub}};
            r_cy     <= sub;
            r_cnt    <= '0;
            r_a_last <= a[WIDTH-1];
            r_b_last <= b[WIDTH-1] ^ sub;
            r_busy   <= 1'b1;
            r_state  <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          r_opa    <= r_opa >> 1;
          r_opb    <= r_opb >> 1;
          r_cy     <= w_cout;
          r_result <= {w_sum, r_result[WIDTH-1:1]};
          r_cnt    <= r_cnt + CNT_W'(1);
          if (r_cnt == CNT_W'(WIDTH - 1)) begin
            r_carry_out <= w_cout;
            r_done      <= 1'b1;
            r_state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          // Start is ignored here; busy drops as we return to IDLE.
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy         = r_busy;
  assign done         = r_done;
  assign result       = r_result;
  assign carry_out    = r_carry_out;
  assign a_last_bit   = r_a_last;
  assign b_last_bit   = r_b_last;
  assign sum_last_bit = r_result[WIDTH-1];

endmodule
